// File: rtl/rec_player.sv
// rec_player: playback sequencer between the note record memory
// and the tone generator.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   start/stop/pause/loop playback controls
//   rec_len               number of valid entries
//   rec_rw/rec_en/rec_cnt memory read strobe and index
//   *_r                   memory read data
//   tone_*                current note to the tone generator
//   busy, done            status; done is a one-cycle pulse
module rec_player #(
  parameter int REC_CNT_BITS   = 5,
  parameter int OCTAVE_BITS    = 2,
  parameter int NOTE_BITS      = 3,
  parameter int LENGTH_BITS    = 3,
  parameter int FULL_NOTE_BITS = 2,
  parameter int TICK_DIV       = 12_500_000,
  parameter int GAP_CYCLES     = 1_000_000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      pause,
  input  logic                      loop,
  input  logic [REC_CNT_BITS:0]     rec_len,
  output logic                      rec_rw,
  output logic                      rec_en,
  output logic [REC_CNT_BITS-1:0]   rec_cnt,
  input  logic [OCTAVE_BITS-1:0]    octave_r,
  input  logic [NOTE_BITS-1:0]      note_r,
  input  logic [LENGTH_BITS-1:0]    length_r,
  input  logic [FULL_NOTE_BITS-1:0] full_note_r,
  output logic                      tone_en,
  output logic [OCTAVE_BITS-1:0]    tone_octave,
  output logic [NOTE_BITS-1:0]      tone_note,
  output logic [FULL_NOTE_BITS-1:0] tone_full_note,
  output logic                      busy,
  output logic                      done
);

  localparam int DUR_W = LENGTH_BITS + $clog2(TICK_DIV);
  localparam logic [DUR_W-1:0] TICK_V = DUR_W'(TICK_DIV);
  localparam logic [DUR_W-1:0] GAP_V  = DUR_W'(GAP_CYCLES);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_FETCH_LO = 3'd1;
  localparam logic [2:0] S_FETCH_HI = 3'd2;
  localparam logic [2:0] S_LATCH    = 3'd3;
  localparam logic [2:0] S_PLAY     = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  logic [2:0]              state;
  logic [REC_CNT_BITS-1:0] idx;
  logic [DUR_W-1:0]        dur;

  logic [REC_CNT_BITS:0]   idx_inc;
  logic [DUR_W-1:0]        dur_load;
  logic [DUR_W-1:0]        dur_dec;
  logic                    run;
  logic                    last;
  logic                    note_end;
  logic                    term;
  logic                    eol;

  assign rec_rw = 1'b0;

  // One extra bit so a full-depth list ends on idx+1 == 2^N.
  assign idx_inc  = {1'b0, idx} + (REC_CNT_BITS+1)'(1);
  assign last     = (idx_inc == rec_len);
  assign dur_load = DUR_W'(length_r) * TICK_V;
  assign dur_dec  = dur - DUR_W'(1);
  assign run      = !pause;
  assign note_end = (state == S_PLAY) && run && (dur <= DUR_W'(1));
  // A zero-length entry terminates the list early.
  assign term     = (state == S_LATCH) && run && (length_r == '0);
  assign eol      = term || (note_end && last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      idx            <= '0;
      dur            <= '0;
      rec_en         <= 1'b0;
      rec_cnt        <= '0;
      tone_en        <= 1'b0;
      tone_octave    <= '0;
      tone_note      <= '0;
      tone_full_note <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        state          <= S_IDLE;
        idx            <= '0;
        dur            <= '0;
        rec_en         <= 1'b0;
        tone_en        <= 1'b0;
        tone_octave    <= '0;
        tone_note      <= '0;
        tone_full_note <= '0;
        busy           <= 1'b0;
      end else begin
        if (state == S_LATCH && run) begin
          tone_octave    <= octave_r;
          tone_note      <= note_r;
          tone_full_note <= full_note_r;
        end
        if (eol) begin
          tone_en <= 1'b0;
          rec_en  <= 1'b0;
          if (loop) begin
            state   <= S_FETCH_LO;
            idx     <= '0;
            rec_cnt <= '0;
          end else begin
            state <= S_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end else begin
          case (state)
            S_IDLE, S_DONE: begin
              if (start) begin
                if (rec_len == '0) begin
                  state <= S_DONE;
                  done  <= 1'b1;
                end else begin
                  state   <= S_FETCH_LO;
                  idx     <= '0;
                  rec_cnt <= '0;
                  rec_en  <= 1'b0;
                  busy    <= 1'b1;
                end
              end
            end
            S_FETCH_LO: begin
              if (run) begin
                state  <= S_FETCH_HI;
                rec_en <= 1'b1;
              end
            end
            S_FETCH_HI: begin
              if (run) state <= S_LATCH;
            end
            S_LATCH: begin
              if (run) begin
                dur     <= dur_load;
                tone_en <= (dur_load > GAP_V);
                state   <= S_PLAY;
              end
            end
            S_PLAY: begin
              if (!run) begin
                tone_en <= 1'b0;
              end else if (note_end) begin
                idx     <= idx_inc[REC_CNT_BITS-1:0];
                rec_cnt <= idx_inc[REC_CNT_BITS-1:0];
                rec_en  <= 1'b0;
                tone_en <= 1'b0;
                state   <= S_FETCH_LO;
              end else begin
                dur     <= dur_dec;
                tone_en <= (dur_dec > GAP_V);
              end
            end
            default: state <= S_IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_rec_player.sv
// tb_rec_player: randomized and directed bench for rec_player
// against a cycle-timeline reference model.
module tb_rec_player;

  localparam int RCB = 5;
  localparam int TD  = 4;
  localparam int GAP = 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         pause = 1'b0;
  logic         loop = 1'b0;
  logic [RCB:0] rec_len = '0;
  logic         rec_rw;
  logic         rec_en;
  logic [RCB-1:0] rec_cnt;
  logic [1:0]   octave_r;
  logic [2:0]   note_r;
  logic [2:0]   length_r;
  logic [1:0]   full_note_r;
  logic         tone_en;
  logic [1:0]   tone_octave;
  logic [2:0]   tone_note;
  logic [1:0]   tone_full_note;
  logic         busy;
  logic         done;

  always #5 clk = ~clk;

  rec_player #(
    .REC_CNT_BITS(RCB), .OCTAVE_BITS(2), .NOTE_BITS(3),
    .LENGTH_BITS(3), .FULL_NOTE_BITS(2),
    .TICK_DIV(TD), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .pause(pause), .loop(loop), .rec_len(rec_len),
    .rec_rw(rec_rw), .rec_en(rec_en), .rec_cnt(rec_cnt),
    .octave_r(octave_r), .note_r(note_r), .length_r(length_r),
    .full_note_r(full_note_r), .tone_en(tone_en),
    .tone_octave(tone_octave), .tone_note(tone_note),
    .tone_full_note(tone_full_note), .busy(busy), .done(done)
  );

  // Entry layout: {octave[9:8], note[7:5], length[4:2], full_note[1:0]}
  logic [9:0] mem [32];
  logic [9:0] rd = '0;
  logic       en_q = 1'b0;

  assign octave_r    = rd[9:8];
  assign note_r      = rd[7:5];
  assign length_r    = rd[4:2];
  assign full_note_r = rd[1:0];

  // Memory returns data on a rising edge of its enable.
  always @(posedge clk) begin
    en_q <= rec_en;
    if (rec_en && !en_q) rd <= mem[rec_cnt];
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  typedef struct {
    bit       ten;
    bit       bsy;
    bit       dn;
    bit       ct;
    bit       cr;
    bit       ren;
    bit [9:0] ent;
    bit [4:0] cnt;
  } exp_t;

  exp_t tq[$];
  int   eol_pos;

  function automatic exp_t blank();
    exp_t e = '{default: 0};
    return e;
  endfunction

  task automatic add_fetch(input int i);
    exp_t e = blank();
    e.bsy = 1;
    e.cr  = 1;
    e.cnt = 5'(i);
    tq.push_back(e);
    e.ren = 1;
    tq.push_back(e);
    e.cr = 0;
    tq.push_back(e);
  endtask

  task automatic add_note(input int i);
    int n;
    n = int'(mem[i][4:2]) * TD;
    for (int c = 0; c < n; c++) begin
      exp_t e = blank();
      e.bsy = 1;
      e.ct  = 1;
      e.ent = mem[i];
      e.ten = (n - c > GAP);
      tq.push_back(e);
    end
  endtask

  task automatic add_done();
    exp_t e = blank();
    e.dn = 1;
    tq.push_back(e);
    e.dn = 0;
    tq.push_back(e);
  endtask

  // Expected per-cycle timeline of one start..done run.
  task automatic build(input int len, input int passes);
    int i;
    int p;
    int l;
    tq.delete();
    eol_pos = -1;
    i = 0;
    p = 0;
    if (len == 0) begin
      add_done();
      return;
    end
    while (1) begin
      add_fetch(i);
      l = int'(mem[i][4:2]);
      if (l != 0) add_note(i);
      if (l == 0 || i + 1 == len) begin
        p++;
        if (p == passes) begin
          add_done();
          break;
        end
        if (eol_pos < 0) eol_pos = tq.size();
        i = 0;
      end else begin
        i++;
      end
    end
  endtask

  // Pause at P edges starting at edge k freezes the state shown
  // at index k-1 with the tone silenced.
  task automatic insert_pause(input int k, input int p);
    exp_t e = tq[k-1];
    e.ten = 0;
    repeat (p) tq.insert(k, e);
  endtask

  task automatic cmp(input int j);
    exp_t e = tq[j];
    check($sformatf("tone_en@%0d", j), 32'(tone_en), 32'(e.ten));
    check($sformatf("busy@%0d", j), 32'(busy), 32'(e.bsy));
    check($sformatf("done@%0d", j), 32'(done), 32'(e.dn));
    check($sformatf("rec_rw@%0d", j), 32'(rec_rw), 32'd0);
    if (e.ct) begin
      check($sformatf("oct@%0d", j), 32'(tone_octave), 32'(e.ent[9:8]));
      check($sformatf("note@%0d", j), 32'(tone_note), 32'(e.ent[7:5]));
      check($sformatf("fn@%0d", j), 32'(tone_full_note),
            32'(e.ent[1:0]));
    end
    if (e.cr) begin
      check($sformatf("rec_en@%0d", j), 32'(rec_en), 32'(e.ren));
      check($sformatf("rec_cnt@%0d", j), 32'(rec_cnt), 32'(e.cnt));
    end
  endtask

  task automatic run_trace(input int hold, input int k, input int p,
                           input int loop_until);
    @(negedge clk);
    start = 1;
    pause = 0;
    loop  = (0 < loop_until);
    for (int j = 0; j < tq.size(); j++) begin
      @(negedge clk);
      cmp(j);
      start = (j + 1 <= hold);
      pause = (j + 1 >= k) && (j + 1 < k + p);
      loop  = (j + 1 < loop_until);
    end
    start = 0;
    pause = 0;
    loop  = 0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rec_en"}, 32'(rec_en), 32'd0);
    check({tag, "_rec_cnt"}, 32'(rec_cnt), 32'd0);
    check({tag, "_tone_en"}, 32'(tone_en), 32'd0);
    check({tag, "_oct"}, 32'(tone_octave), 32'd0);
    check({tag, "_note"}, 32'(tone_note), 32'd0);
    check({tag, "_fn"}, 32'(tone_full_note), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_rw"}, 32'(rec_rw), 32'd0);
  endtask

  task automatic load_basic();
    for (int i = 0; i < 32; i++) mem[i] = 10'($urandom);
    mem[0] = {2'd1, 3'd3, 3'd2, 2'd0};
    mem[1] = {2'd2, 3'd5, 3'd1, 2'd1};
    rec_len = 6'd2;
  endtask

  initial begin
    int sz;
    int hold;
    int k;
    int p;
    int len;

    // Reset state
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1;
    @(negedge clk);

    // Basic two-note playback
    load_basic();
    build(2, 1);
    run_trace(0, 0, 0, 0);

    // Empty list
    rec_len = 6'd0;
    build(0, 1);
    run_trace(0, 0, 0, 0);

    // Zero-length terminator in entry 1
    load_basic();
    mem[1][4:2] = 3'd0;
    rec_len = 6'd4;
    build(4, 1);
    run_trace(0, 0, 0, 0);

    // Pause for 10 cycles mid-note
    load_basic();
    build(2, 1);
    insert_pause(6, 10);
    run_trace(0, 6, 10, 0);

    // stop together with start from idle
    @(negedge clk);
    start = 1;
    stop  = 1;
    @(negedge clk);
    start = 0;
    stop  = 0;
    check("stopstart_busy", 32'(busy), 32'd0);
    check("stopstart_done", 32'(done), 32'd0);
    @(negedge clk);
    check("stopstart_busy2", 32'(busy), 32'd0);

    // stop (with pause) mid-note
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (5) @(negedge clk);
    check("prestop_tone", 32'(tone_en), 32'd1);
    stop  = 1;
    pause = 1;
    @(negedge clk);
    stop  = 0;
    pause = 0;
    check_zero("stop");
    repeat (3) @(negedge clk);
    check("poststop_done", 32'(done), 32'd0);
    check("poststop_busy", 32'(busy), 32'd0);

    // Loop over full depth, then drop loop
    for (int i = 0; i < 32; i++)
      mem[i] = {2'($urandom), 3'($urandom),
                3'($urandom_range(1, 2)), 2'($urandom)};
    rec_len = 6'd32;
    build(32, 2);
    run_trace(0, 0, 0, eol_pos + 5);

    // Async reset mid-note, then replay
    load_basic();
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 0;
    #1 check_zero("async_rst");
    #4 rst_n = 1;
    @(negedge clk);
    check("postrst_busy", 32'(busy), 32'd0);
    build(2, 1);
    run_trace(0, 0, 0, 0);

    // Randomized lists, start held while busy, random pauses
    for (int it = 0; it < 20; it++) begin
      for (int i = 0; i < 32; i++) mem[i] = 10'($urandom);
      len = $urandom_range(0, 8);
      rec_len = 6'(len);
      build(len, 1);
      sz = tq.size();
      k = 0;
      p = 0;
      if (sz > 3 && $urandom_range(0, 1) == 1) begin
        k = $urandom_range(1, sz - 2);
        p = $urandom_range(1, 6);
        insert_pause(k, p);
        sz = tq.size();
      end
      hold = (sz >= 3) ? $urandom_range(0, sz - 3) : 0;
      run_trace(hold, k, p, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
